cal_core_row_sched: RTL and testbench
=====================================

# cal_core_row_sched

Row scheduler for the calibration core. On a frame `start` it walks the I rows of a frame. For each row it reads the H row and the A alpha columns from the host-side buffers (1-cycle read latency) and streams them into the core's `H_row`/`alpha_u_col` inputs with correct valid/last framing. It then waits for the row's `beta` result and republishes it tagged with its row index. It keeps exactly one row in flight, and provides done, abort, timeout and spurious-result reporting.

## Interface
- `J`, 14, columns per H row (alpha column has J bytes)
- `I`, 7, rows per frame
- `A`, 2, alpha columns per row / beta lanes
- `TIMEOUT`, 4096, max cycles to wait for beta per row (≥2)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  frame start request, sampled only in IDLE
- `abort`  in  1  synchronous frame abort
- `h_rd_en`  out  1  H buffer read strobe
- `h_rd_addr`  out  $clog2(I)  H row address
- `h_rd_data`  in  J  H row data, valid cycle after `h_rd_en`
- `a_rd_en`  out  1  alpha buffer read strobe
- `a_rd_addr`  out  $clog2(I*A)  alpha address = row*A + col
- `a_rd_data`  in  J*8  alpha column data, valid cycle after `a_rd_en`
- `core_H_row`  out  J  to core `H_row`
- `core_H_row_tvalid`  out  1  to core
- `core_alpha_u_col`  out  J*8  to core
- `core_alpha_u_col_tvalid`  out  1  to core
- `core_alpha_u_col_tlast`  out  1  to core, marks column A-1
- `core_beta`  in  A*8  from core
- `core_beta_tvalid`  in  1  from core, one pulse per row
- `beta_out`  out  A*8  captured row result
- `beta_out_row`  out  $clog2(I)  row index of `beta_out`
- `beta_out_valid`  out  1  1-cycle pulse
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  1-cycle pulse at frame end (normal, abort or timeout)
- `err_timeout`  out  1  sticky; cleared by accepted `start`
- `err_spurious`  out  1  sticky; cleared by accepted `start`

## Operation
- FSM states: IDLE, LOAD_H, LOAD_A, WAIT_BETA, DONE.
- **IDLE:** `start`=1 → LOAD_H. The accept sets row=0 and clears both error flags.
- **LOAD_H (1 cycle):** `h_rd_en`=1, `h_rd_addr`=row. Next state LOAD_A with col=0.
- **LOAD_A (A cycles):** `a_rd_en`=1, `a_rd_addr`=row*A+col, col increments. After col=A-1 → WAIT_BETA and the timer clears.
- **Core drive:**
  - `core_H_row_tvalid` = `h_rd_en` delayed 1 cycle; `core_H_row` = `h_rd_data`.
  - `core_alpha_u_col_tvalid` = `a_rd_en` delayed 1 cycle; `core_alpha_u_col` = `a_rd_data`.
  - `tlast` = delayed (col==A-1).
  - Data outputs are pass-through. They are don't-care when the matching valid is low.
- **WAIT_BETA:**
  - `core_beta_tvalid` → capture `core_beta` into `beta_out`, `beta_out_row`=row, `beta_out_valid` pulse next cycle.
  - Then row==I-1 → DONE; otherwise row+1 and → LOAD_H.
  - Timer reaching TIMEOUT-1 without beta → `err_timeout`=1 and → DONE.
  - If beta and timeout occur on the same cycle, beta wins.
- **DONE (1 cycle):** `done`=1 → IDLE.
- **abort:** in any non-IDLE state → DONE next cycle. Delayed core valids produced by a read already issued are suppressed. No `beta_out_valid` is issued after abort is sampled.
- **Spurious beta:** `core_beta_tvalid` outside WAIT_BETA sets `err_spurious`. The result is dropped.
- `start` outside IDLE is ignored.

## Timing
- **Reset values:**
  - All strobes, valids, `busy`, `done` and error flags = 0.
  - Addresses = 0; `beta_out` = 0; `beta_out_row` = 0; FSM = IDLE.
- All outputs are registered except the pass-through data buses.
- **Cycle sequence** (`start` sampled at cycle s):
  - s+1: `h_rd_en`, addr 0.
  - s+2: `core_H_row_tvalid`; `a_rd_en` addr 0.
  - s+2..s+1+A: alpha reads.
  - s+3..s+2+A: core alpha valids, `tlast` at s+2+A.
  - s+2+A: WAIT_BETA entered.
- Beta sampled at cycle b → `beta_out_valid` at b+1. The next row's `h_rd_en` is also at b+1.
- Row period = A+2+(beta latency) cycles.
- `done` follows the last `beta_out_valid` by 1 cycle.
- Reset mid-frame returns to IDLE immediately, with no `done`.

## Test plan
- **Nominal frame:** I=7, A=2; core model returns beta=row*0x0101 twenty cycles after `tlast`.
  - H addresses 0..6; alpha addresses 0..13 in order; `tlast` on odd addresses.
  - Seven `beta_out_valid` pulses with rows 0..6 and correct data.
  - One `done`; no error flags.
- **Start while busy:** `start` pulsed at row 2 → ignored; frame completes unchanged; exactly one `done`.
- **Timeout:** TIMEOUT=64; model withholds beta on row 3.
  - `beta_out` for rows 0..2 only.
  - `err_timeout`=1 at 64 cycles after WAIT_BETA entry; `done` 1 cycle later; no further reads.
- **Abort during LOAD_A of row 1:**
  - No core alpha valid after the abort cycle+1.
  - `done` next cycle; `beta_out_valid` only for row 0; next `start` runs a clean frame.
- **Spurious beta in IDLE:** `core_beta_tvalid` with 0xBEEF → `err_spurious`=1, no `beta_out_valid`; the flag clears on the next accepted `start`.
- **Reset mid-row-4:** all outputs return to reset values asynchronously; no `done`; a restart yields the full 7-row sequence.

Source files
------------

// File: rtl/cal_core_row_sched.sv
// Row scheduler for the calibration core: walks the rows of a frame, streams H/alpha
// from the host buffers into the core, and republishes each row's beta tagged with its row.
module cal_core_row_sched #(
    parameter int unsigned J       = 14,
    parameter int unsigned I       = 7,
    parameter int unsigned A       = 2,
    parameter int unsigned TIMEOUT = 4096,
    localparam int unsigned RW     = $clog2(I),
    localparam int unsigned AW     = $clog2(I * A),
    localparam int unsigned BW     = A * 8,
    localparam int unsigned DW     = J * 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          h_rd_en,
    output logic [RW-1:0] h_rd_addr,
    input  logic [J-1:0]  h_rd_data,
    output logic          a_rd_en,
    output logic [AW-1:0] a_rd_addr,
    input  logic [DW-1:0] a_rd_data,
    output logic [J-1:0]  core_H_row,
    output logic          core_H_row_tvalid,
    output logic [DW-1:0] core_alpha_u_col,
    output logic          core_alpha_u_col_tvalid,
    output logic          core_alpha_u_col_tlast,
    input  logic [BW-1:0] core_beta,
    input  logic          core_beta_tvalid,
    output logic [BW-1:0] beta_out,
    output logic [RW-1:0] beta_out_row,
    output logic          beta_out_valid,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          err_spurious
);

    localparam int unsigned CW = (A > 1) ? $clog2(A) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_H    = 3'd1;
    localparam logic [2:0] ST_LOAD_A    = 3'd2;
    localparam logic [2:0] ST_WAIT_BETA = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    logic [2:0]    r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [TW-1:0] r_timer;

    logic [2:0]    w_nxt_state;
    logic [RW-1:0] w_nxt_row;
    logic [CW-1:0] w_nxt_col;
    logic [TW-1:0] w_nxt_timer;
    logic [AW-1:0] w_nxt_a_addr;
    logic          w_accept;
    logic          w_capture;
    logic          w_timeout;
    logic          w_abort;

    logic          r_h_rd_en;
    logic [RW-1:0] r_h_rd_addr;
    logic          r_a_rd_en;
    logic          r_a_rd_last;
    logic [AW-1:0] r_a_rd_addr;
    logic          r_h_tvalid;
    logic          r_a_tvalid;
    logic          r_a_tlast;
    logic [BW-1:0] r_beta_out;
    logic [RW-1:0] r_beta_out_row;
    logic          r_beta_out_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_err_timeout;
    logic          r_err_spurious;

    // Abort only acts while a frame is actively loading or waiting; DONE already ends it.
    assign w_abort = abort && ((r_state == ST_LOAD_H) || (r_state == ST_LOAD_A) ||
                               (r_state == ST_WAIT_BETA));

    // State and row/column/timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_row   <= w_nxt_row;
            r_col   <= w_nxt_col;
            r_timer <= w_nxt_timer;
        end
    end

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_row   = r_row;
        w_nxt_col   = r_col;
        w_nxt_timer = r_timer;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nxt_state = ST_LOAD_H;
                    w_nxt_row   = '0;
                    w_accept    = 1'b1;
                end
            end
            ST_LOAD_H: begin
                w_nxt_state = ST_LOAD_A;
                w_nxt_col   = '0;
            end
            ST_LOAD_A: begin
                if (r_col == CW'(A - 1)) begin
                    w_nxt_state = ST_WAIT_BETA;
                    w_nxt_timer = '0;
                end else begin
                    w_nxt_col = r_col + CW'(1);
                end
            end
            ST_WAIT_BETA: begin
                w_nxt_timer = r_timer + TW'(1);
                // A beta arriving on the timeout cycle still counts as a result.
                if (core_beta_tvalid) begin
                    w_capture = 1'b1;
                    if (r_row == RW'(I - 1)) begin
                        w_nxt_state = ST_DONE;
                    end else begin
                        w_nxt_row   = r_row + RW'(1);
                        w_nxt_state = ST_LOAD_H;
                    end
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_nxt_state = ST_DONE;
            w_capture   = 1'b0;
            w_timeout   = 1'b0;
        end
    end

    assign w_nxt_a_addr = AW'(32'(w_nxt_row) * A + 32'(w_nxt_col));

    // Registered read strobes, core framing, result capture and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_rd_en        <= 1'b0;
            r_h_rd_addr      <= '0;
            r_a_rd_en        <= 1'b0;
            r_a_rd_last      <= 1'b0;
            r_a_rd_addr      <= '0;
            r_h_tvalid       <= 1'b0;
            r_a_tvalid       <= 1'b0;
            r_a_tlast        <= 1'b0;
            r_beta_out       <= '0;
            r_beta_out_row   <= '0;
            r_beta_out_valid <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err_timeout    <= 1'b0;
            r_err_spurious   <= 1'b0;
        end else begin
            r_h_rd_en   <= (w_nxt_state == ST_LOAD_H);
            r_a_rd_en   <= (w_nxt_state == ST_LOAD_A);
            r_a_rd_last <= (w_nxt_state == ST_LOAD_A) && (w_nxt_col == CW'(A - 1));
            if (w_nxt_state == ST_LOAD_H) begin
                r_h_rd_addr <= w_nxt_row;
            end
            if (w_nxt_state == ST_LOAD_A) begin
                r_a_rd_addr <= w_nxt_a_addr;
            end
            // Reads already in flight when abort lands never reach the core.
            r_h_tvalid <= r_h_rd_en & ~w_abort;
            r_a_tvalid <= r_a_rd_en & ~w_abort;
            r_a_tlast  <= r_a_rd_last & r_a_rd_en & ~w_abort;

            r_beta_out_valid <= w_capture;
            if (w_capture) begin
                r_beta_out     <= core_beta;
                r_beta_out_row <= r_row;
            end

            r_busy <= (w_nxt_state != ST_IDLE);
            r_done <= (r_state == ST_DONE);

            if (w_accept) begin
                r_err_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end

            if (core_beta_tvalid && (r_state != ST_WAIT_BETA)) begin
                r_err_spurious <= 1'b1;
            end else if (w_accept) begin
                r_err_spurious <= 1'b0;
            end
        end
    end

    assign h_rd_en                 = r_h_rd_en;
    assign h_rd_addr               = r_h_rd_addr;
    assign a_rd_en                 = r_a_rd_en;
    assign a_rd_addr               = r_a_rd_addr;
    assign core_H_row              = h_rd_data;
    assign core_H_row_tvalid       = r_h_tvalid;
    assign core_alpha_u_col        = a_rd_data;
    assign core_alpha_u_col_tvalid = r_a_tvalid;
    assign core_alpha_u_col_tlast  = r_a_tlast;
    assign beta_out                = r_beta_out;
    assign beta_out_row            = r_beta_out_row;
    assign beta_out_valid          = r_beta_out_valid;
    assign busy                    = r_busy;
    assign done                    = r_done;
    assign err_timeout             = r_err_timeout;
    assign err_spurious            = r_err_spurious;

endmodule

// File: tb/tb_cal_core_row_sched.sv
// Scoreboard bench for cal_core_row_sched: buffer models, a delayed-beta core model,
// and expected row results queued as the core model produces them.
module tb_cal_core_row_sched;

    localparam int unsigned J   = 14;
    localparam int unsigned I   = 7;
    localparam int unsigned A   = 2;
    localparam int unsigned TMO = 64;
    localparam int unsigned RW  = $clog2(I);
    localparam int unsigned AW  = $clog2(I * A);
    localparam int unsigned BW  = A * 8;
    localparam int unsigned DW  = J * 8;
    localparam int          LAT = 20;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          h_rd_en;
    logic [RW-1:0] h_rd_addr;
    logic [J-1:0]  h_rd_data;
    logic          a_rd_en;
    logic [AW-1:0] a_rd_addr;
    logic [DW-1:0] a_rd_data;
    logic [J-1:0]  core_H_row;
    logic          core_H_row_tvalid;
    logic [DW-1:0] core_alpha_u_col;
    logic          core_alpha_u_col_tvalid;
    logic          core_alpha_u_col_tlast;
    logic [BW-1:0] core_beta;
    logic          core_beta_tvalid;
    logic [BW-1:0] beta_out;
    logic [RW-1:0] beta_out_row;
    logic          beta_out_valid;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_spurious;

    cal_core_row_sched #(.J(J), .I(I), .A(A), .TIMEOUT(TMO)) u_dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start                   (start),
        .abort                   (abort),
        .h_rd_en                 (h_rd_en),
        .h_rd_addr               (h_rd_addr),
        .h_rd_data               (h_rd_data),
        .a_rd_en                 (a_rd_en),
        .a_rd_addr               (a_rd_addr),
        .a_rd_data               (a_rd_data),
        .core_H_row              (core_H_row),
        .core_H_row_tvalid       (core_H_row_tvalid),
        .core_alpha_u_col        (core_alpha_u_col),
        .core_alpha_u_col_tvalid (core_alpha_u_col_tvalid),
        .core_alpha_u_col_tlast  (core_alpha_u_col_tlast),
        .core_beta               (core_beta),
        .core_beta_tvalid        (core_beta_tvalid),
        .beta_out                (beta_out),
        .beta_out_row            (beta_out_row),
        .beta_out_valid          (beta_out_valid),
        .busy                    (busy),
        .done                    (done),
        .err_timeout             (err_timeout),
        .err_spurious            (err_spurious)
    );

    typedef struct packed {
        logic [RW-1:0] row;
        logic [BW-1:0] data;
    } exp_t;

    logic [J-1:0]  h_mem [I];
    logic [DW-1:0] a_mem [I*A];
    exp_t          exp_q [$];
    exp_t          mon_e;

    logic          mdl_tvalid;
    logic [BW-1:0] mdl_beta;
    logic          spur_tvalid;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int h_cnt, hv_cnt, a_cnt, av_cnt, bo_cnt, done_cnt;
    int tl_row, cd, pend_row, withhold;
    int tl_cyc, to_cyc, done_cyc, bo_cyc;
    logic prev_to;

    assign core_beta_tvalid = mdl_tvalid | spur_tvalid;
    assign core_beta        = spur_tvalid ? BW'(16'hBEEF) : mdl_beta;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Host buffers with one cycle of read latency
    always @(posedge clk) begin
        if (h_rd_en) h_rd_data <= h_mem[h_rd_addr];
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor and core model, sampled away from the active edge
    always @(negedge clk) begin
        mdl_tvalid = 1'b0;
        if (!rst_n || (start && !busy)) begin
            h_cnt = 0; hv_cnt = 0; a_cnt = 0; av_cnt = 0; bo_cnt = 0; done_cnt = 0;
            tl_row = 0; cd = 0; pend_row = 0;
            tl_cyc = 0; to_cyc = 0; done_cyc = 0; bo_cyc = 0;
            exp_q.delete();
            if (!rst_n) begin
                mdl_beta = '0;
                prev_to  = 1'b0;
            end
        end
        if (rst_n) begin
            if (h_rd_en) begin
                chk("h_addr", 128'(h_rd_addr), 128'(h_cnt));
                h_cnt++;
            end
            if (core_H_row_tvalid) begin
                chk("h_data", 128'(core_H_row), 128'(h_mem[hv_cnt % I]));
                hv_cnt++;
            end
            if (a_rd_en) begin
                chk("a_addr", 128'(a_rd_addr), 128'(a_cnt));
                a_cnt++;
            end
            if (core_alpha_u_col_tvalid) begin
                chk("a_data", 128'(core_alpha_u_col), 128'(a_mem[av_cnt % (I*A)]));
                chk("tlast", 128'(core_alpha_u_col_tlast), 128'((av_cnt % A) == (A - 1)));
                av_cnt++;
            end
            if (beta_out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("bo_unexpected", 128'(beta_out_valid), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("bo_row", 128'(beta_out_row), 128'(mon_e.row));
                    chk("bo_data", 128'(beta_out), 128'(mon_e.data));
                end
                bo_cnt++;
                bo_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err_timeout && !prev_to) to_cyc = cyc;
            prev_to = err_timeout;

            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mdl_tvalid = 1'b1;
                    mdl_beta   = BW'(pend_row * 257);
                    mon_e.row  = RW'(pend_row);
                    mon_e.data = mdl_beta;
                    exp_q.push_back(mon_e);
                end
            end
            if (core_alpha_u_col_tvalid && core_alpha_u_col_tlast) begin
                if (tl_row == withhold) begin
                    tl_cyc = cyc;
                end else begin
                    pend_row = tl_row;
                    cd       = LAT;
                end
                tl_row++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        for (int k = 0; k < maxc; k++) begin
            if (done_cnt > 0) break;
            idle(1);
        end
        chk({tag, "_done_seen"}, 128'(done_cnt > 0), 128'(1));
    endtask

    task automatic wait_h_row(input string tag, input int row);
        int k;
        for (k = 0; k < 600; k++) begin
            if (h_rd_en && (int'(h_rd_addr) == row)) break;
            idle(1);
        end
        chk({tag, "_h_row_reached"}, 128'(k < 600), 128'(1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_flags"},
            128'({h_rd_en, a_rd_en, core_H_row_tvalid, core_alpha_u_col_tvalid,
                  core_alpha_u_col_tlast, beta_out_valid, busy, done, err_timeout, err_spurious}),
            128'(0));
        chk({tag, "_addrs"}, 128'({h_rd_addr, a_rd_addr}), 128'(0));
        chk({tag, "_beta_out"}, 128'(beta_out), 128'(0));
        chk({tag, "_beta_row"}, 128'(beta_out_row), 128'(0));
    endtask

    task automatic chk_frame(input string tag, input int rows);
        chk({tag, "_h_reads"}, 128'(h_cnt), 128'(rows));
        chk({tag, "_h_valids"}, 128'(hv_cnt), 128'(rows));
        chk({tag, "_a_reads"}, 128'(a_cnt), 128'(rows * A));
        chk({tag, "_a_valids"}, 128'(av_cnt), 128'(rows * A));
        chk({tag, "_beta_outs"}, 128'(bo_cnt), 128'(rows));
        chk({tag, "_dones"}, 128'(done_cnt), 128'(1));
        chk({tag, "_done_after_bo"}, 128'(done_cyc - bo_cyc), 128'(1));
        chk({tag, "_queue_left"}, 128'(exp_q.size()), 128'(0));
        chk({tag, "_errs"}, 128'({err_timeout, err_spurious}), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        start       = 1'b0;
        abort       = 1'b0;
        spur_tvalid = 1'b0;
        rst_n       = 1'b0;
        withhold    = -1;
        for (int r = 0; r < I; r++) h_mem[r] = J'($urandom);
        for (int r = 0; r < I * A; r++) a_mem[r] = DW'({$urandom, $urandom, $urandom, $urandom});
        idle(3);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        idle(2);

        // Nominal frame
        pulse_start();
        chk("nom_busy", 128'(busy), 128'(1));
        chk("nom_first_h", 128'({h_rd_en, h_rd_addr}), 128'({1'b1, RW'(0)}));
        wait_done("nom", 800);
        idle(5);
        chk_frame("nom", I);

        // Start pulsed while busy is ignored
        pulse_start();
        wait_h_row("busy_start", 2);
        pulse_start();
        wait_done("busy_start", 800);
        idle(5);
        chk_frame("busy_start", I);

        // Beta withheld on row 3
        withhold = 3;
        pulse_start();
        wait_done("tmo", 800);
        idle(10);
        withhold = -1;
        chk("tmo_h_reads", 128'(h_cnt), 128'(4));
        chk("tmo_a_reads", 128'(a_cnt), 128'(4 * A));
        chk("tmo_beta_outs", 128'(bo_cnt), 128'(3));
        chk("tmo_dones", 128'(done_cnt), 128'(1));
        chk("tmo_flag", 128'(err_timeout), 128'(1));
        chk("tmo_latency", 128'(to_cyc - tl_cyc), 128'(TMO));
        chk("tmo_done_lag", 128'(done_cyc - to_cyc), 128'(1));

        // Abort during the first alpha read of row 1
        pulse_start();
        chk("abort_tmo_cleared", 128'(err_timeout), 128'(0));
        for (int k = 0; k < 200; k++) begin
            if (a_rd_en && (int'(a_rd_addr) == A)) break;
            idle(1);
        end
        chk("abort_reached_row1", 128'({a_rd_en, a_rd_addr}), 128'({1'b1, AW'(A)}));
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        wait_done("abort", 10);
        idle(5);
        chk("abort_a_valids", 128'(av_cnt), 128'(A));
        chk("abort_a_reads", 128'(a_cnt), 128'(A + 1));
        chk("abort_h_reads", 128'(h_cnt), 128'(2));
        chk("abort_beta_outs", 128'(bo_cnt), 128'(1));
        chk("abort_dones", 128'(done_cnt), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        pulse_start();
        wait_done("post_abort", 800);
        idle(5);
        chk_frame("post_abort", I);

        // Spurious beta while idle
        spur_tvalid = 1'b1;
        idle(1);
        spur_tvalid = 1'b0;
        idle(3);
        chk("spur_flag", 128'(err_spurious), 128'(1));
        chk("spur_busy", 128'(busy), 128'(0));
        pulse_start();
        idle(1);
        chk("spur_cleared", 128'(err_spurious), 128'(0));
        wait_done("post_spur", 800);
        idle(5);
        chk_frame("post_spur", I);

        // Asynchronous reset in the middle of row 4
        pulse_start();
        wait_h_row("mid_rst", 4);
        idle(6);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        idle(2);
        rst_n = 1'b1;
        idle(30);
        chk("mid_rst_no_done", 128'(done_cnt), 128'(0));
        chk("mid_rst_idle", 128'(busy), 128'(0));
        pulse_start();
        wait_done("post_rst", 800);
        idle(5);
        chk_frame("post_rst", I);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
